// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer so in_ready is a pure flop output.
// Optional forwarding source enabled by defining EX_MEM_FWD_EN.
module ex_mem_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_alu_out,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic [2:0]         in_funct3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_alu_out,
  output logic [XLEN-1:0]    out_rs2,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic [2:0]         out_funct3,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data
);

  // state | meaning
  // EMPTY | no entry held; out_valid=0
  // ONE   | MAIN holds the head entry; SKID unused
  // TWO   | MAIN = head, SKID = next; in_ready=0
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]    alu_out;
    logic [XLEN-1:0]    rs2;
    logic [RADDR_W-1:0] rd;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         funct3;
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t cap;
  logic   in_xfer;
  logic   out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // x0 is never written, so the write enable is dropped as the entry is captured
  always_comb begin
    cap.alu_out   = in_alu_out;
    cap.rs2       = in_rs2;
    cap.rd        = in_rd;
    cap.reg_write = in_reg_write & (in_rd != '0);
    cap.mem_read  = in_mem_read;
    cap.mem_write = in_mem_write;
    cap.funct3    = in_funct3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      main_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q    <= cap;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= cap;
          end else if (in_xfer) begin
            skid_q   <= cap;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            // clearing MAIN keeps the control outputs low while nothing is valid
            main_q    <= '0;
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          main_q    <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_alu_out   = main_q.alu_out;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_mem_read  = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_funct3    = main_q.funct3;

`ifdef EX_MEM_FWD_EN
  // loads have no value yet in this stage, so they cannot be a bypass source
  assign fwd_valid = out_valid & main_q.reg_write & ~main_q.mem_read;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.alu_out;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; fwd expectations follow EX_MEM_FWD_EN.
module tb_ex_mem_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;
`ifdef EX_MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_alu_out, in_rs2;
  logic [RW-1:0]   in_rd;
  logic            in_reg_write, in_mem_read, in_mem_write;
  logic [2:0]      in_funct3;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_alu_out, out_rs2;
  logic [RW-1:0]   out_rd;
  logic            out_reg_write, out_mem_read, out_mem_write;
  logic [2:0]      out_funct3;
  logic            fwd_valid;
  logic [RW-1:0]   fwd_rd;
  logic [XLEN-1:0] fwd_data;

  int total = 0;
  int bad   = 0;

  ex_mem_stage #(.XLEN(XLEN), .RADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_out(out_alu_out), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_funct3(out_funct3),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] s,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] f3);
    in_valid = v; in_alu_out = a; in_rs2 = s; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr; in_mem_write = mw; in_funct3 = f3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    flush = 0; out_ready = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_alu_out !== 32'h0 || out_rd !== 5'd0) begin bad++; $display("FAIL reset_data got=%h/%0d exp=0/0", out_alu_out, out_rd); end
    total++; if ({out_reg_write, out_mem_read, out_mem_write, fwd_valid} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {out_reg_write, out_mem_read, out_mem_write, fwd_valid}); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1;
    drive(1, 32'd12, 32'd0, 5'd5, 1, 0, 0, 3'd2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_alu_out !== 32'd12 || out_rd !== 5'd5 || out_reg_write !== 1'b1)
      begin bad++; $display("FAIL single_out got v=%b alu=%0d rd=%0d rw=%b exp v=1 alu=12 rd=5 rw=1", out_valid, out_alu_out, out_rd, out_reg_write); end
    total++; if (fwd_valid !== FWD || fwd_rd !== (FWD ? 5'd5 : 5'd0) || fwd_data !== (FWD ? 32'd12 : 32'd0))
      begin bad++; $display("FAIL single_fwd got v=%b rd=%0d d=%0d fwd_en=%b", fwd_valid, fwd_rd, fwd_data, FWD); end
    tick();
    total++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL single_drain got v=%b rw=%b rdy=%b exp 0 0 1", out_valid, out_reg_write, in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(1, 32'h11, 32'h1, 5'd1, 1, 0, 0, 0);
    tick();
    total++; if (in_ready !== 1'b1 || out_alu_out !== 32'h11) begin bad++; $display("FAIL bp_first got rdy=%b out=%h exp 1 11", in_ready, out_alu_out); end
    drive(1, 32'h22, 32'h2, 5'd2, 1, 0, 0, 0);
    tick();
    total++; if (in_ready !== 1'b0 || out_alu_out !== 32'h11) begin bad++; $display("FAIL bp_full got rdy=%b out=%h exp 0 11", in_ready, out_alu_out); end
    drive(1, 32'h33, 32'h3, 5'd3, 1, 0, 0, 0);
    tick();
    tick();
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_alu_out !== 32'h11 || out_rs2 !== 32'h1)
      begin bad++; $display("FAIL bp_hold got rdy=%b v=%b out=%h rs2=%h exp 0 1 11 1", in_ready, out_valid, out_alu_out, out_rs2); end
    out_ready = 1;
    tick();
    total++; if (out_alu_out !== 32'h22 || out_rd !== 5'd2 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got out=%h rd=%0d rdy=%b exp 22 2 1", out_alu_out, out_rd, in_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_alu_out !== 32'h33 || out_rs2 !== 32'h3) begin bad++; $display("FAIL bp_third got v=%b out=%h rs2=%h exp 1 33 3", out_valid, out_alu_out, out_rs2); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got v=%b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + i, 32'(i * 3), 5'(i + 8), 1, 0, 0, 3'(i));
      tick();
      if (out_valid !== 1'b1 || out_alu_out !== 32'h100 + i || out_rs2 !== 32'(i * 3) ||
          out_funct3 !== 3'(i) || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL b2b_%0d got v=%b out=%h rs2=%0d f3=%0d rdy=%b exp out=%h", i, out_valid, out_alu_out, out_rs2, out_funct3, in_ready, 32'h100 + i);
      end
    end
    total++; if (errs != 0) bad++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_x0_and_fields();
    out_ready = 1;
    drive(1, 32'hABCD, 32'h0, 5'd0, 1, 0, 0, 0);
    tick();
    total++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || fwd_valid !== 1'b0)
      begin bad++; $display("FAIL x0_write got v=%b rw=%b fwd=%b exp 1 0 0", out_valid, out_reg_write, fwd_valid); end
    drive(1, 32'h40, 32'hDEAD, 5'd7, 1, 1, 1, 3'd5);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if ({out_reg_write, out_mem_read, out_mem_write} !== 3'b111 || out_funct3 !== 3'd5 || out_rs2 !== 32'hDEAD || fwd_valid !== 1'b0)
      begin bad++; $display("FAIL pass_fields got ctl=%b f3=%0d rs2=%h fwd=%b exp 111 5 dead 0", {out_reg_write, out_mem_read, out_mem_write}, out_funct3, out_rs2, fwd_valid); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 32'hA1, 0, 5'd1, 1, 0, 1, 0);
    tick();
    drive(1, 32'hA2, 0, 5'd2, 1, 0, 1, 0);
    tick();
    drive(1, 32'hA3, 0, 5'd3, 1, 0, 1, 0);
    flush = 1;
    tick();
    flush = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_write !== 1'b0 || out_mem_write !== 1'b0)
      begin bad++; $display("FAIL flush_clear got v=%b rdy=%b rw=%b mw=%b exp 0 1 0 0", out_valid, in_ready, out_reg_write, out_mem_write); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got v=%b out=%h exp 0", out_valid, out_alu_out); end
    drive(1, 32'hA4, 0, 5'd4, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_alu_out !== 32'hA4) begin bad++; $display("FAIL flush_after got v=%b out=%h exp 1 a4", out_valid, out_alu_out); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    drive(1, 32'hB1, 0, 5'd9, 1, 1, 0, 3'd2);
    tick();
    total++; if (fwd_valid !== 1'b0 || out_mem_read !== 1'b1) begin bad++; $display("FAIL load_no_fwd got fwd=%b mr=%b exp 0 1", fwd_valid, out_mem_read); end
    drive(1, 32'hB2, 0, 5'd10, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_pre got rdy=%b exp 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_write !== 1'b0 || out_mem_read !== 1'b0)
      begin bad++; $display("FAIL arst_now got v=%b rdy=%b rw=%b mr=%b exp 0 1 0 0", out_valid, in_ready, out_reg_write, out_mem_read); end
    rst = 1'b0;
    out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_after got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_x0_and_fields();
    test_flush();
    do_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
